// File: rtl/glitch_sequencer_pkg.sv
// Shared definitions for the glitch sequencer and its program ROM: opcodes,
// bus/ack encodings, instruction field layout and FSM states.
package glitch_sequencer_pkg;

    localparam int unsigned INSTR_W  = 12;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PT_W     = 8;
    localparam int unsigned DNUM_W   = 8;
    localparam int unsigned DLY_W    = 32;
    localparam int unsigned PT_EXT_W = PT_W + 1;

    localparam int unsigned OP_MSB   = 11;
    localparam int unsigned OP_LSB   = 10;
    localparam int unsigned BUS_BIT  = 9;
    localparam int unsigned DATA_MSB = 8;
    localparam int unsigned DATA_LSB = 1;
    localparam int unsigned ACK_BIT  = 0;

    typedef enum logic [1:0] {
        OP_I2C_CHK = 2'b00,
        OP_DAC_UP  = 2'b01,
        OP_DELAY   = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    localparam logic PRIV_BUS = 1'b0;
    localparam logic MAIN_BUS = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NAK      = 1'b1;

    // Field order mirrors the ROM word layout, MSB first.
    typedef struct packed {
        op_e               op;
        logic              bus;
        logic [DATA_W-1:0] data;
        logic              ack;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_DELAY    = 3'd3,
        ST_WAIT_I2C = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op   = op_e'(w[OP_MSB:OP_LSB]);
        d.bus  = w[BUS_BIT];
        d.data = w[DATA_MSB:DATA_LSB];
        d.ack  = w[ACK_BIT];
        return d;
    endfunction

    function automatic logic [INSTR_W-1:0] make_instr(input op_e op, input logic bus,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic ack);
        logic [INSTR_W-1:0] w;
        w                    = '0;
        w[OP_MSB:OP_LSB]     = op;
        w[BUS_BIT]           = bus;
        w[DATA_MSB:DATA_LSB] = data;
        w[ACK_BIT]           = ack;
        return w;
    endfunction

endpackage

// File: rtl/glitch_delay_counter.sv
// 32-bit down-counter for DELAY instructions; saturates at zero, never wraps.
module glitch_delay_counter
    import glitch_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             enable,
    output logic             zero_c,
    output logic             last_c
);

    logic [DLY_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - DLY_W'(1);
        end
    end

    assign zero_c = (count == '0);
    // Count of one marks the final cycle of the delay window.
    assign last_c = (count == DLY_W'(1));

endmodule

// File: rtl/glitch_sequencer.sv
// ROM-programmed glitch sequencer: steps DAC codes, timed delays and I2C
// byte checks, rewinding a check run to its first instruction on mismatch.
module glitch_sequencer
    import glitch_sequencer_pkg::*;
#(
    parameter int unsigned prog_len = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [PT_W-1:0]   instr_pt,
    input  logic [INSTR_W-1:0] instr,
    output logic [DNUM_W-1:0] delay_num,
    input  logic [DLY_W-1:0]  delay_len,
    input  logic              mon_valid,
    input  logic              mon_bus,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              mon_ack,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_we,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    localparam logic [PT_EXT_W-1:0] PROG_END = PT_EXT_W'(prog_len);

    state_e            state, state_nxt;
    logic [PT_W-1:0]   instr_pt_nxt;
    logic [DNUM_W-1:0] delay_num_nxt;
    logic [PT_W-1:0]   chk_base, chk_base_nxt;
    logic              in_run, in_run_nxt;
    logic [DATA_W-1:0] dac_data_nxt;
    logic              dac_we_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              fault_nxt;

    instr_t             ins_c;
    logic [PT_EXT_W-1:0] pt_inc_ext_c;
    logic               last_instr_c;
    logic               advance_c;
    logic               cnt_load_c;
    logic               cnt_en_c;
    logic               cnt_zero_c;
    logic               cnt_last_c;
    logic               bus_hit_c;
    logic               byte_ok_c;

    assign ins_c        = decode_instr(instr);
    assign pt_inc_ext_c = {1'b0, instr_pt} + PT_EXT_W'(1);
    assign last_instr_c = (pt_inc_ext_c == PROG_END);
    assign bus_hit_c    = mon_valid && (mon_bus == ins_c.bus);
    assign byte_ok_c    = (mon_data == ins_c.data) && (mon_ack == ins_c.ack);

    glitch_delay_counter u_delay_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (delay_len),
        .enable   (cnt_en_c),
        .zero_c   (cnt_zero_c),
        .last_c   (cnt_last_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        instr_pt_nxt  = instr_pt;
        delay_num_nxt = delay_num;
        chk_base_nxt  = chk_base;
        in_run_nxt    = in_run;
        dac_data_nxt  = dac_data;
        dac_we_nxt    = 1'b0;
        done_nxt      = done;
        fault_nxt     = fault;
        advance_c     = 1'b0;
        cnt_load_c    = 1'b0;
        cnt_en_c      = 1'b0;

        if (abort) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
            fault_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (start) begin
                        state_nxt    = ST_FETCH;
                        instr_pt_nxt = '0;
                        in_run_nxt   = 1'b0;
                        done_nxt     = 1'b0;
                        fault_nxt    = 1'b0;
                    end
                end
                ST_FETCH: begin
                    unique case (ins_c.op)
                        OP_DAC_UP: begin
                            dac_data_nxt = ins_c.data;
                            dac_we_nxt   = 1'b1;
                            in_run_nxt   = 1'b0;
                            advance_c    = 1'b1;
                        end
                        OP_DELAY: begin
                            delay_num_nxt = DNUM_W'(ins_c.data);
                            in_run_nxt    = 1'b0;
                            state_nxt     = ST_LOAD;
                        end
                        OP_I2C_CHK: begin
                            // Only the first check of a run sets the rewind point.
                            if (!in_run) begin
                                chk_base_nxt = instr_pt;
                            end
                            in_run_nxt = 1'b1;
                            state_nxt  = ST_WAIT_I2C;
                        end
                        OP_RSVD: begin
                            state_nxt = ST_FAULT;
                            fault_nxt = 1'b1;
                        end
                    endcase
                end
                ST_LOAD: begin
                    cnt_load_c = 1'b1;
                    if (delay_len == '0) begin
                        advance_c = 1'b1;
                    end else begin
                        state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    cnt_en_c = 1'b1;
                    if (cnt_last_c || cnt_zero_c) begin
                        advance_c = 1'b1;
                    end
                end
                ST_WAIT_I2C: begin
                    if (bus_hit_c) begin
                        if (byte_ok_c) begin
                            advance_c = 1'b1;
                        end else begin
                            instr_pt_nxt = chk_base;
                            state_nxt    = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            if (advance_c) begin
                if (last_instr_c) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    instr_pt_nxt = pt_inc_ext_c[PT_W-1:0];
                    state_nxt    = ST_FETCH;
                end
            end
        end

        busy_nxt = (state_nxt == ST_FETCH) || (state_nxt == ST_LOAD) ||
                   (state_nxt == ST_DELAY) || (state_nxt == ST_WAIT_I2C);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            instr_pt  <= '0;
            delay_num <= '0;
            chk_base  <= '0;
            in_run    <= 1'b0;
            dac_data  <= '0;
            dac_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            instr_pt  <= instr_pt_nxt;
            delay_num <= delay_num_nxt;
            chk_base  <= chk_base_nxt;
            in_run    <= in_run_nxt;
            dac_data  <= dac_data_nxt;
            dac_we    <= dac_we_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fault     <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a small program ROM and delay table
// are rewritten per scenario and outputs are compared with hand-derived values.
module tb_glitch_sequencer;
    import glitch_sequencer_pkg::*;

    localparam int unsigned PLEN = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [PT_W-1:0]     instr_pt;
    logic [INSTR_W-1:0]  instr;
    logic [DNUM_W-1:0]   delay_num;
    logic [DLY_W-1:0]    delay_len;
    logic                mon_valid;
    logic                mon_bus;
    logic [DATA_W-1:0]   mon_data;
    logic                mon_ack;
    logic [DATA_W-1:0]   dac_data;
    logic                dac_we;
    logic                busy;
    logic                done;
    logic                fault;

    logic [INSTR_W-1:0]  rom     [0:255];
    logic [DLY_W-1:0]    dly_tab [0:255];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign instr     = rom[instr_pt];
    assign delay_len = dly_tab[delay_num];

    glitch_sequencer #(.prog_len(PLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .instr_pt  (instr_pt),
        .instr     (instr),
        .delay_num (delay_num),
        .delay_len (delay_len),
        .mon_valid (mon_valid),
        .mon_bus   (mon_bus),
        .mon_data  (mon_data),
        .mon_ack   (mon_ack),
        .dac_data  (dac_data),
        .dac_we    (dac_we),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic strobe(input logic bus, input logic [7:0] d, input logic a);
        mon_valid = 1'b1;
        mon_bus   = bus;
        mon_data  = d;
        mon_ack   = a;
        tick(1);
        mon_valid = 1'b0;
        tick(2);
    endtask

    // Start the program and log dac_we pulses until done/fault or budget expiry.
    task automatic run_log(output int n_we, output int gap,
                           output logic [7:0] d0, output logic [7:0] d1);
        int c0;
        n_we = 0;
        gap  = -1;
        d0   = '0;
        d1   = '0;
        c0   = 0;
        pulse_start();
        check("start_busy", busy, 1'b1);
        check("start_done_clr", done, 1'b0);
        for (int b = 0; b < 500; b++) begin
            if (dac_we) begin
                if (n_we == 0) begin
                    c0 = cyc;
                    d0 = dac_data;
                end else begin
                    gap = cyc - c0;
                    d1  = dac_data;
                end
                n_we++;
            end
            if (done || fault) break;
            tick(1);
        end
        check("run_end", done | fault, 1'b1);
    endtask

    initial begin
        int n_we;
        int gap;
        int we_seen;
        logic [7:0] d0;
        logic [7:0] d1;

        for (int i = 0; i < 256; i++) begin
            rom[i]     = '0;
            dly_tab[i] = '0;
        end
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mon_valid = 1'b0;
        mon_bus   = 1'b0;
        mon_data  = '0;
        mon_ack   = 1'b0;

        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_pt", instr_pt, 8'h00);
        check("rst_dac_we", dac_we, 1'b0);
        check("rst_done_fault", {done, fault}, 2'b00);
        rst_n = 1'b1;
        tick(1);

        // DAC 8E, DELAY idx3 (64 cycles), DAC 00
        rom[0]     = make_instr(OP_DAC_UP, PRIV_BUS, 8'h8E, ACK);
        rom[1]     = make_instr(OP_DELAY,  PRIV_BUS, 8'h03, ACK);
        rom[2]     = make_instr(OP_DAC_UP, PRIV_BUS, 8'h00, ACK);
        dly_tab[3] = 32'h40;
        run_log(n_we, gap, d0, d1);
        check("d_we_count", n_we, 2);
        check("d_we_data0", d0, 8'h8E);
        check("d_we_data1", d1, 8'h00);
        check("d_we_gap", gap, 32'h43);
        check("d_done", done, 1'b1);
        check("d_busy", busy, 1'b0);
        check("d_pt", instr_pt, 8'h02);
        check("d_delay_num", delay_num, 8'h03);
        tick(1);
        check("d_we_single", dac_we, 1'b0);

        // Zero-length delay: FETCH, LOAD, next FETCH
        rom[0]     = make_instr(OP_DAC_UP, PRIV_BUS, 8'h11, ACK);
        rom[1]     = make_instr(OP_DELAY,  PRIV_BUS, 8'h00, ACK);
        rom[2]     = make_instr(OP_DAC_UP, PRIV_BUS, 8'h22, ACK);
        dly_tab[0] = 32'h0;
        run_log(n_we, gap, d0, d1);
        check("z_we_count", n_we, 2);
        check("z_we_gap", gap, 3);
        check("z_we_data1", d1, 8'h22);
        check("z_pt", instr_pt, 8'h02);

        // Reserved opcode at instr_pt 1
        rom[0] = make_instr(OP_DAC_UP, PRIV_BUS, 8'h33, ACK);
        rom[1] = make_instr(OP_RSVD,   PRIV_BUS, 8'h00, ACK);
        rom[2] = make_instr(OP_DAC_UP, PRIV_BUS, 8'h44, ACK);
        run_log(n_we, gap, d0, d1);
        check("f_we_count", n_we, 1);
        check("f_we_data0", d0, 8'h33);
        check("f_flags", {fault, done, busy}, 3'b100);
        check("f_pt", instr_pt, 8'h01);
        pulse_start();
        check("f_restart_pt", instr_pt, 8'h00);
        check("f_restart_flags", {fault, busy}, 2'b01);
        tick(3);

        // I2C run {84/ACK, 03/ACK} with a bad second byte forcing a rewind
        rom[0] = make_instr(OP_I2C_CHK, PRIV_BUS, 8'h84, ACK);
        rom[1] = make_instr(OP_I2C_CHK, PRIV_BUS, 8'h03, ACK);
        rom[2] = make_instr(OP_DAC_UP,  PRIV_BUS, 8'h5A, ACK);
        pulse_start();
        tick(2);
        strobe(PRIV_BUS, 8'h84, ACK);
        check("i_pt_after_84", instr_pt, 8'h01);
        strobe(PRIV_BUS, 8'h05, ACK);
        check("i_pt_rewind", instr_pt, 8'h00);
        check("i_busy_rewind", busy, 1'b1);
        strobe(PRIV_BUS, 8'h84, ACK);
        check("i_pt_after_84b", instr_pt, 8'h01);
        strobe(PRIV_BUS, 8'h03, ACK);
        check("i_done", done, 1'b1);
        check("i_pt_end", instr_pt, 8'h02);
        check("i_dac_data", dac_data, 8'h5A);

        // Other-bus strobes are ignored
        pulse_start();
        tick(2);
        strobe(MAIN_BUS, 8'h84, ACK);
        check("b_pt_hold", instr_pt, 8'h00);
        check("b_busy", busy, 1'b1);
        strobe(PRIV_BUS, 8'h84, ACK);
        check("b_pt_adv", instr_pt, 8'h01);

        // Abort while waiting on I2C
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("a_flags", {busy, done, fault, dac_we}, 4'b0000);
        check("a_dac_data", dac_data, 8'h5A);
        strobe(PRIV_BUS, 8'h03, ACK);
        check("a_idle_ignore", {busy, done}, 2'b00);

        // Start while busy is ignored; then reset mid-DELAY
        rom[0] = make_instr(OP_DAC_UP, PRIV_BUS, 8'h8E, ACK);
        rom[1] = make_instr(OP_DELAY,  PRIV_BUS, 8'h03, ACK);
        rom[2] = make_instr(OP_DAC_UP, PRIV_BUS, 8'h00, ACK);
        pulse_start();
        tick(5);
        pulse_start();
        tick(2);
        check("s_busy_pt", instr_pt, 8'h01);
        check("s_busy_num", delay_num, 8'h03);
        check("s_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("r_flags", {busy, done, fault, dac_we}, 4'b0000);
        check("r_pt", instr_pt, 8'h00);
        check("r_delay_num", delay_num, 8'h00);
        check("r_dac_data", dac_data, 8'h00);
        tick(2);
        rst_n   = 1'b1;
        we_seen = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (dac_we) we_seen++;
        end
        check("r_no_we", we_seen, 0);
        check("r_idle", {busy, done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter prog_len, default 14, number of valid program instructions (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin program at instruction 0, sampled in IDLE/DONE/FAULT.
REQ-005 SHALL have port abort  input  1  return to IDLE from any state.
REQ-006 SHALL have port instr_pt  output  8  registered address to program ROM.
REQ-007 SHALL have port instr  input  12  ROM word {op[11:10], bus[9], data[8:1], ack[0]}, combinational from instr_pt.
REQ-008 SHALL have port delay_num  output  8  registered index to ROM delay table.
REQ-009 SHALL have port delay_len  input  32  ROM delay length in clk cycles, combinational from delay_num.
REQ-010 SHALL have ports mon_valid/mon_bus/mon_data/mon_ack  input  1/1/8/1  one-cycle strobe per byte observed by the I2C monitor, with its bus, byte and ACK(0)/NAK(1) bit.
REQ-011 SHALL have ports dac_data/dac_we  output  8/1  DAC code and one-cycle write strobe.
REQ-012 SHALL have ports busy/done/fault  output  1  status levels.

Function
REQ-013 SHALL decode op: 00 I2C_CHK, 01 DAC_UP, 10 DELAY, 11 reserved.
REQ-014 SHALL implement states IDLE, FETCH, LOAD, DELAY, WAIT_I2C, DONE, FAULT; busy=1 in FETCH/LOAD/DELAY/WAIT_I2C only.
REQ-015 IDLE/DONE/FAULT with start=1 SHALL set instr_pt=0, clear done/fault, enter FETCH next cycle.
REQ-016 FETCH SHALL decode instr in one cycle; instr_pt is stable for the whole instruction.
REQ-017 DAC_UP SHALL, in FETCH, register dac_data=data and pulse dac_we for exactly the following cycle, then advance; total 1 cycle per instruction.
REQ-018 DELAY SHALL, in FETCH, register delay_num=data, go LOAD; LOAD SHALL load counter=delay_len; delay_len=0 SHALL advance from LOAD; otherwise DELAY SHALL last exactly delay_len cycles, then advance.
REQ-019 Counter SHALL be 32 bits, decrement by 1, never wrap; delay_len=32'hFFFFFFFF is legal.
REQ-020 I2C_CHK SHALL enter WAIT_I2C and wait indefinitely for mon_valid with mon_bus==bus.
REQ-021 Matching strobe with mon_data==data and mon_ack==ack SHALL advance; mismatch SHALL set instr_pt=chk_base and remain in WAIT_I2C-via-FETCH.
REQ-022 chk_base SHALL record instr_pt of the first I2C_CHK of each consecutive I2C_CHK run; a rewind re-matches the whole run.
REQ-023 Strobes with mon_bus!=bus, or outside WAIT_I2C, SHALL be ignored.
REQ-024 Advance SHALL set instr_pt+1 and go FETCH; if instr_pt+1==prog_len, SHALL go DONE with instr_pt held and done=1.
REQ-025 op 11 SHALL enter FAULT, fault=1, instr_pt held.
REQ-026 abort SHALL have priority over start and every transition: next state IDLE, dac_data unchanged, dac_we=0.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, instr_pt=0, delay_num=0, counter=0, chk_base=0, dac_data=8'h00, dac_we=0, busy=0, done=0, fault=0.
REQ-029 Reset mid-DELAY or mid-WAIT_I2C SHALL discard progress; no dac_we on release.

Structure
REQ-030 Opcode constants (I2C_CHK, DAC_UP, DELAY), bus constants (PRIV_BUS, MAIN_BUS), ACK/NAK and the instr field positions SHALL live in a shared package also used by the ROM.
REQ-031 The delay counter SHALL be a sub-module glitch_delay_counter (load, enable, zero flag).

Verification
REQ-032 Program {DAC_UP 8E, DELAY idx3 (len 0x40), DAC_UP 00}, start -> dac_we pulses carrying 8E then 00, exactly 0x40 DELAY cycles between them, done=1, instr_pt=2.
REQ-033 DELAY with delay_len=0 -> LOAD advances directly, 0 DELAY cycles, next instruction fetched 2 cycles after DELAY fetch.
REQ-034 I2C_CHK run {84/ACK, 03/ACK} on PRIV_BUS; feed 84, 05, then 84, 03 -> rewind to chk_base after 05, advance only after second 84, 03 pair.
REQ-035 mon strobes on MAIN_BUS while waiting on PRIV_BUS -> no advance, instr_pt unchanged.
REQ-036 Word with op=11 at instr_pt=1 -> fault=1, busy=0, instr_pt=1; subsequent start -> restart at 0, fault=0.
REQ-037 rst_n low mid-DELAY and abort mid-WAIT_I2C -> all outputs at reset/IDLE values, no spurious dac_we.
